// File: rtl/mult_sequencer_pkg.sv
// Shared package for the EXE-stage multiply sequencer.
// Holds the word length, the MULT execute command code, the sequencer FSM
// state encodings and the iteration counter width.
package mult_sequencer_pkg;

  // Datapath word length shared by the whole pipeline.
  localparam int WORD_LEN = 32;

  // Execute command code the controller attaches to MULT.
  localparam logic [3:0] EXE_MULT = 4'b1010;

  // Counter width needed to count WORD_LEN iterations (WORD_LEN-1 down to 0).
  localparam int MSEQ_CNT_LEN = $clog2(WORD_LEN);

  // Sequencer FSM state encodings.
  typedef enum logic [1:0] {
    MSEQ_IDLE = 2'd0,
    MSEQ_RUN  = 2'd1,
    MSEQ_DONE = 2'd2
  } mseq_state_t;

endpackage

// File: rtl/mult_shift_add_step.sv
// One radix-2 shift-add iteration of the multiplier.
// Adds the multiplicand into the upper accumulator half when the current
// multiplier bit is set (WIDTH+1-bit sum keeps the carry), then shifts
// {carry, accumulator} right by one. Purely combinational.
import mult_sequencer_pkg::*;

module mult_shift_add_step #(
  parameter int WIDTH = WORD_LEN
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               mbit,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  assign addend = mbit ? mcand : '0;

  // Widened add on the upper half, then drop the lowest accumulator bit.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_next = {sum, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle radix-2 shift-add multiplier sequencer for the EXE stage.
// Accepts a MULT from IDLE, runs exactly WIDTH iterations in RUN, and
// commits the 2*WIDTH-bit product into HI/LO on the edge into DONE, where
// `done` pulses for one cycle. `stall` freezes the front of the pipeline
// for the accept cycle plus every RUN cycle.
//
// Handshake: `start` is a level meaning "EXE holds a MULT"; it is only
// sampled in IDLE, and an accept happens on an IDLE edge with start=1 and
// flush=0. `flush` aborts RUN without touching HI/LO; it is ignored in DONE.
//
// Build option: define MULT_SIGNED_EN for a two's-complement multiply
// (operands converted to magnitudes on accept, product negated on commit).
// Without it, operands are unsigned and no sign logic exists.
import mult_sequencer_pkg::*;

module mult_sequencer #(
  parameter int WIDTH = WORD_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mseq_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;
  logic [PW-1:0]    result;
  logic             accept;

`ifdef MULT_SIGNED_EN
  logic sign_q;

  // Magnitudes of the two's-complement operands; -2^(WIDTH-1) maps onto
  // itself, which is the correct unsigned magnitude.
  assign src1_mag = src1[WIDTH-1] ? (~src1 + WIDTH'(1)) : src1;
  assign src2_mag = src2[WIDTH-1] ? (~src2 + WIDTH'(1)) : src2;
  // Final product, negated when the operand signs differed.
  assign result   = sign_q ? (~acc_next + PW'(1)) : acc_next;
`else
  assign src1_mag = src1;
  assign src2_mag = src2;
  assign result   = acc_next;
`endif

  assign accept = (state == MSEQ_IDLE) && start && !flush;
  assign busy   = (state != MSEQ_IDLE);
  assign stall  = accept || (state == MSEQ_RUN);

  mult_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .mbit     (mplier[0]),
    .acc_next (acc_next)
  );

  // Sequencer FSM: operand capture, iteration, HI/LO commit and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MSEQ_IDLE;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      product_hi <= '0;
      product_lo <= '0;
      done       <= 1'b0;
`ifdef MULT_SIGNED_EN
      sign_q     <= 1'b0;
`endif
    end else begin
      case (state)
        MSEQ_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            mcand  <= src1_mag;
            mplier <= src2_mag;
            acc    <= '0;
            cnt    <= CNT_LAST;
`ifdef MULT_SIGNED_EN
            sign_q <= src1[WIDTH-1] ^ src2[WIDTH-1];
`endif
            state  <= MSEQ_RUN;
          end
        end
        MSEQ_RUN: begin
          if (flush) begin
            state <= MSEQ_IDLE;
          end else begin
            acc    <= acc_next;
            mplier <= mplier >> 1;
            if (cnt == '0) begin
              // Last iteration: commit the product so it is valid in DONE.
              product_hi <= result[PW-1:WIDTH];
              product_lo <= result[WIDTH-1:0];
              done       <= 1'b1;
              state      <= MSEQ_DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        MSEQ_DONE: begin
          done  <= 1'b0;
          state <= MSEQ_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= MSEQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed testbench for mult_sequencer (32-bit).
// Compile with +define+MULT_SIGNED_EN to check the signed build.
module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;

  int checks   = 0;
  int failures = 0;

  mult_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .flush      (flush),
    .src1       (src1),
    .src2       (src2),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo)
  );

  // Clock: 10 ns period; outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  // Drive one MULT from IDLE; returns at the falling edge of the DONE cycle.
  // done_at is the cycle index after the accept edge (-1 on timeout).
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input bit keep_start,
                          output int stall_cycles, output int done_at, output logic stall_at_done);
    @(negedge clk);
    src1 = a; src2 = b; start = 1'b1;
    #1;
    stall_cycles  = 0;
    done_at       = -1;
    stall_at_done = 1'bx;
    if (stall === 1'b1) stall_cycles++;
    for (int c = 1; c <= 60 && done_at < 0; c++) begin
      @(negedge clk);
      if (stall === 1'b1) stall_cycles++;
      if (done === 1'b1) begin
        done_at       = c;
        stall_at_done = stall;
      end
    end
    if (!keep_start) start = 1'b0;
    checks++;
    if (done_at < 0) begin failures++; $display("FAIL run_timeout: no done within 60 cycles for %0h*%0h", a, b); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; src1 = '0; src2 = '0;
    repeat (2) @(negedge clk);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0b want 0", stall); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (product_hi !== 32'h0 || product_lo !== 32'h0) begin failures++; $display("FAIL reset_hilo: got %0h_%0h want 0_0", product_hi, product_lo); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy: got %0b want 0", busy); end
  endtask

  task automatic test_basic();
    int sc; int da; logic sd;
    run_mult(32'd3, 32'd5, 1'b0, sc, da, sd);
    checks++; if (sc != 33) begin failures++; $display("FAIL basic_stall_cycles: got %0d want 33", sc); end
    checks++; if (da != 33) begin failures++; $display("FAIL basic_done_cycle: got %0d want 33", da); end
    checks++; if (sd !== 1'b0) begin failures++; $display("FAIL basic_stall_in_done: got %0b want 0", sd); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_in_done: got %0b want 1", busy); end
    checks++; if (product_hi !== 32'h0) begin failures++; $display("FAIL basic_hi: got %0h want 0", product_hi); end
    checks++; if (product_lo !== 32'd15) begin failures++; $display("FAIL basic_lo: got %0h want f", product_lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_after_done: got done=%0b busy=%0b want 0 0", done, busy); end
    checks++; if (product_lo !== 32'd15) begin failures++; $display("FAIL basic_lo_held: got %0h want f", product_lo); end
  endtask

  task automatic test_vectors();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] eh [6];
    logic [31:0] el [6];
    int sc; int da; logic sd;
    va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF;
    va[1] = 32'h80000000; vb[1] = 32'h00000001;
    va[2] = 32'h00010000; vb[2] = 32'h00010000;
    va[3] = 32'hFFFFFFFF; vb[3] = 32'h00000002;
    va[4] = 32'h00000000; vb[4] = 32'hDEADBEEF;
    va[5] = 32'h00000007; vb[5] = 32'h00000009;
`ifdef MULT_SIGNED_EN
    eh[0] = 32'h00000000; el[0] = 32'h00000001;
    eh[1] = 32'hFFFFFFFF; el[1] = 32'h80000000;
    eh[3] = 32'hFFFFFFFF; el[3] = 32'hFFFFFFFE;
`else
    eh[0] = 32'hFFFFFFFE; el[0] = 32'h00000001;
    eh[1] = 32'h00000000; el[1] = 32'h80000000;
    eh[3] = 32'h00000001; el[3] = 32'hFFFFFFFE;
`endif
    eh[2] = 32'h00000001; el[2] = 32'h00000000;
    eh[4] = 32'h00000000; el[4] = 32'h00000000;
    eh[5] = 32'h00000000; el[5] = 32'h0000003F;
    for (int i = 0; i < 6; i++) begin
      run_mult(va[i], vb[i], 1'b0, sc, da, sd);
      checks++; if (da != 33) begin failures++; $display("FAIL vec%0d_latency: got %0d want 33", i, da); end
      checks++; if (product_hi !== eh[i] || product_lo !== el[i]) begin failures++; $display("FAIL vec%0d_product: got %h_%h want %h_%h", i, product_hi, product_lo, eh[i], el[i]); end
    end
  endtask

  task automatic test_flush();
    int sc; int da; logic sd; int n_done;
    run_mult(32'd3, 32'd5, 1'b0, sc, da, sd);
    @(negedge clk);
    src1 = 32'd7; src2 = 32'd9; start = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_running: got busy=%0b want 1", busy); end
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL flush_idle: got busy=%0b done=%0b want 0 0", busy, done); end
    checks++; if (product_hi !== 32'h0 || product_lo !== 32'd15) begin failures++; $display("FAIL flush_hilo: got %0h_%0h want 0_f", product_hi, product_lo); end
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL flush_no_done: got %0d pulses want 0", n_done); end
  endtask

  task automatic test_reset_mid_run();
    int sc; int da; logic sd;
    @(negedge clk);
    src1 = 32'd7; src2 = 32'd9; start = 1'b1;
    repeat (6) @(negedge clk);
    #1 rst = 1'b1; start = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_mid_ctrl: got busy=%0b stall=%0b done=%0b want 0 0 0", busy, stall, done); end
    checks++; if (product_hi !== 32'h0 || product_lo !== 32'h0) begin failures++; $display("FAIL rst_mid_hilo: got %0h_%0h want 0_0", product_hi, product_lo); end
    @(negedge clk);
    rst = 1'b0;
    run_mult(32'd2, 32'd2, 1'b0, sc, da, sd);
    checks++; if (product_hi !== 32'h0 || product_lo !== 32'd4) begin failures++; $display("FAIL rst_mid_next: got %0h_%0h want 0_4", product_hi, product_lo); end
  endtask

  task automatic test_back_to_back();
    int sc; int da; logic sd; int n_done; int da2;
    run_mult(32'd3, 32'd5, 1'b1, sc, da, sd);
    src1 = 32'd2; src2 = 32'd6;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap: got busy=%0b stall=%0b done=%0b want 0 1 0", busy, stall, done); end
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_second_accept: got busy=%0b done=%0b want 1 0", busy, done); end
    n_done = 0; da2 = -1;
    for (int c = 2; c <= 60 && da2 < 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin n_done++; da2 = c; end
    end
    checks++; if (da2 != 33) begin failures++; $display("FAIL b2b_second_latency: got %0d want 33", da2); end
    checks++; if (product_hi !== 32'h0 || product_lo !== 32'd12) begin failures++; $display("FAIL b2b_second_product: got %0h_%0h want 0_c", product_hi, product_lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_final_idle: got done=%0b busy=%0b want 0 0", done, busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_flush();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle radix-2 shift-add multiplier sequencer for the EXE stage. The controller marks MULT with `EXE_MULT` and no register write-back. This block owns the iterative multiply datapath. It freezes the pipeline while the product is computed and holds the 2·WIDTH-bit result in dedicated HI/LO product registers. It sits beside the ALU in EXE, and its `stall` output is OR-ed into the pipeline freeze logic.

## Interface
- `WIDTH`, default `` `WORD_LEN `` (32): operand width; product is 2·WIDTH.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: EXE holds a valid MULT (`EXE_CMD == EXE_MULT`); sampled only in IDLE.
- `flush` input 1: squash the in-flight MULT; aborts RUN.
- `src1` input WIDTH: multiplicand, captured on accept.
- `src2` input WIDTH: multiplier, captured on accept.
- `stall` output 1: freeze PC/IF/ID/EXE registers.
- `busy` output 1: state ≠ IDLE.
- `done` output 1: one-cycle pulse when HI/LO is updated.
- `product_hi` output WIDTH: upper product half; held until the next completed MULT.
- `product_lo` output WIDTH: lower product half; held until the next completed MULT.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when `start && !flush`. On that edge:
  - load the multiplicand and multiplier,
  - clear the 2·WIDTH accumulator,
  - set the counter to WIDTH−1.
- RUN, one iteration per cycle:
  - if multiplier[0] is set, add the multiplicand into the accumulator upper half, keeping the carry;
  - shift {carry, accumulator} right by 1;
  - shift the multiplier right by 1;
  - decrement the counter.
- RUN → DONE on the edge that executes the iteration with counter == 0. Exactly WIDTH iterations; no early exit for zero operands.
- DONE: `product_hi`/`product_lo` are loaded from the accumulator (after sign fix-up, see Configuration) and `done`=1. DONE → IDLE unconditionally.
- `stall` = (IDLE && `start` && !`flush`) || RUN. `stall` is combinational so the MULT stays in EXE.
- In DONE, `stall`=0, so MULT retires that edge. `start` is still high in DONE and must not retrigger; `start` is ignored outside IDLE.
- `flush` in RUN → IDLE next edge. HI/LO are unchanged and `done` does not pulse. `flush` in DONE has no effect; the result is already committed.
- `start` and `flush` in IDLE on the same cycle: no accept.
- Arithmetic: accumulator upper-half add is WIDTH+1 bits, so the carry is never lost. All arithmetic is unsigned modulo 2^(2·WIDTH).

## Timing
- Reset values:
  - state=IDLE, counter=0, accumulator=0;
  - `product_hi`=`product_lo`=0;
  - `stall`=0 (given `start`=0), `busy`=0, `done`=0.
- `rst` mid-RUN: immediate return to IDLE, HI/LO cleared, no `done`.
- Latency: accept at edge N; RUN occupies cycles N+1..N+WIDTH; `done` is high in cycle N+WIDTH+1.
- HI/LO are valid from that cycle onward.
- `stall` is high for WIDTH+1 cycles per MULT: the accept cycle plus WIDTH RUN cycles.
- Back-to-back MULTs: the next accept is earliest one cycle after DONE.

## Configuration
- `MULT_SIGNED_EN` defined (signed multiply):
  - two's-complement operands are converted to magnitudes on accept;
  - the result sign (src1[MSB] ^ src2[MSB]) is stored;
  - the 2·WIDTH product is negated in DONE if the stored sign is set;
  - −2^(WIDTH−1) is handled: its magnitude fits unsigned.
- `MULT_SIGNED_EN` undefined: operands are used unsigned; no sign logic is synthesized.
- Latency is identical in both builds.

## Structure
- Shared package additions:
  - FSM state encodings `MSEQ_IDLE`, `MSEQ_RUN`, `MSEQ_DONE`;
  - `MSEQ_CNT_LEN` = clog2(`WORD_LEN`).
- `WORD_LEN` and `EXE_MULT` are reused from the shared package.
- One sub-module, `mult_shift_add_step`: combinational single iteration taking accumulator, multiplicand, and multiplier bit, returning the next accumulator.
- The FSM, counter, and HI/LO registers stay in `mult_sequencer`.

## Test plan
- Reset, then `src1`=3, `src2`=5, `start` → `stall` high 33 cycles; `done` in cycle 33 after accept; HI=0, LO=15; `stall`=0 in the DONE cycle.
- `src1`=`src2`=0xFFFFFFFF:
  - unsigned build → HI=0xFFFFFFFE, LO=0x00000001;
  - `MULT_SIGNED_EN` build → HI=0, LO=1.
- `MULT_SIGNED_EN`, `src1`=0x80000000, `src2`=0x00000001 → HI=0xFFFFFFFF, LO=0x80000000.
- Complete 3×5, then start 7×9 and assert `flush` 10 cycles into RUN → IDLE next cycle, no `done`, HI/LO still 0/15.
- `rst` pulsed mid-RUN after a prior completed MULT → `busy`, `stall`, `done`, and HI/LO all 0 asynchronously; the next MULT 2×2 gives LO=4.
- `start` held high through DONE and one extra cycle → exactly one `done` pulse; the second accept occurs only in the following IDLE cycle.
